// File: rtl/add_some_bitz_pkg.sv
// Shared types, register-map offsets and the byte-strobe merge helper for the
// add_some_bitz AXI4-Lite register file.
package add_some_bitz_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } sum_state_t;

  // Register indices above the operand block, relative to NUM_OPS.
  localparam int unsigned CTRL_OFS   = 0;
  localparam int unsigned STATUS_OFS = 1;
  localparam int unsigned RESULT_OFS = 2;
  localparam int unsigned CARRY_OFS  = 3;

  // Sized for the widest supported bus; callers truncate to DATA_WIDTH.
  function automatic logic [63:0] apply_wstrb(input logic [63:0] old,
                                              input logic [63:0] data,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/add_some_bitz_regs_if.sv
// AXI4-Lite bundle between the VIP master and the add_some_bitz register file.
interface add_some_bitz_regs_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/add_some_bitz_sum_engine.sv
// Sequential sum engine: adds one operand per cycle, counts carry-outs
// (saturating) and publishes RESULT/CARRY on completion.
module add_some_bitz_sum_engine
  import add_some_bitz_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_OPS    = 4,
  localparam int unsigned IdxW      = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [IdxW-1:0]       op_idx_o,
  input  logic [DATA_WIDTH-1:0] op_data_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] carry_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OPS - 1);

  sum_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] carry_q, carry_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, op_data_i};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          idx_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH] && (cnt_q != '1)) cnt_d = cnt_q + DATA_WIDTH'(1);
        idx_d = idx_q + IdxW'(1);
        if (idx_q == LastIdx) state_d = DONE;
      end
      DONE: begin
        result_d = acc_q;
        carry_d  = cnt_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign op_idx_o = idx_q;
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;

endmodule

// File: rtl/add_some_bitz_regs.sv
// AXI4-Lite slave holding NUM_OPS operand registers plus CTRL/STATUS/RESULT/CARRY,
// with a sequential sum engine behind the CTRL.START bit.
module add_some_bitz_regs
  import add_some_bitz_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_OPS    = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  add_some_bitz_regs_if.slave s_axi,
  output logic                busy_o
);

  localparam int unsigned AddrLsb = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IdxW    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  logic [DATA_WIDTH-1:0]   ops_q [NUM_OPS];
  logic [DATA_WIDTH-1:0]   ops_d [NUM_OPS];
  logic                    aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    bvalid_q;
  resp_t                   bresp_q;
  logic                    rvalid_q;
  resp_t                   rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    commit;
  logic                    start;
  resp_t                   wr_resp;
  int unsigned             wr_idx;
  int unsigned             rd_idx;
  logic [DATA_WIDTH-1:0]   rd_data;
  resp_t                   rd_resp;

  logic [IdxW-1:0]         op_idx;
  logic [DATA_WIDTH-1:0]   op_data;
  logic [DATA_WIDTH-1:0]   result, carry;
  logic                    busy, done;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, awaddr_q[AddrLsb-1:0],
                         s_axi.araddr[AddrLsb-1:0]};

  assign s_axi.awready = !aw_held_q && !bvalid_q;
  assign s_axi.wready  = !w_held_q && !bvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = !rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign busy_o        = busy;

  // Both halves of the write are held: this cycle performs the update.
  assign commit = aw_held_q && w_held_q;

  always_comb begin
    ops_d   = ops_q;
    wr_resp = OKAY;
    start   = 1'b0;
    wr_idx  = 32'(awaddr_q[ADDR_WIDTH-1:AddrLsb]);
    if (commit) begin
      if (wr_idx < NUM_OPS) begin
        if (busy) begin
          wr_resp = SLVERR;
        end else begin
          for (int unsigned k = 0; k < NUM_OPS; k++) begin
            if (wr_idx == k) begin
              ops_d[k] = DATA_WIDTH'(apply_wstrb(64'(ops_q[k]), 64'(wdata_q), 8'(wstrb_q)));
            end
          end
        end
      end else if (wr_idx == NUM_OPS + CTRL_OFS) begin
        // START while busy is acknowledged but has no effect.
        start = wstrb_q[0] && wdata_q[0] && !busy;
      end else begin
        wr_resp = SLVERR;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = OKAY;
    rd_idx  = 32'(s_axi.araddr[ADDR_WIDTH-1:AddrLsb]);
    if (rd_idx < NUM_OPS) begin
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
        if (rd_idx == k) rd_data = ops_q[k];
      end
    end else if (rd_idx == NUM_OPS + CTRL_OFS) begin
      rd_data = '0;
    end else if (rd_idx == NUM_OPS + STATUS_OFS) begin
      rd_data = DATA_WIDTH'({done, busy});
    end else if (rd_idx == NUM_OPS + RESULT_OFS) begin
      rd_data = result;
    end else if (rd_idx == NUM_OPS + CARRY_OFS) begin
      rd_data = carry;
    end else begin
      rd_resp = SLVERR;
    end
  end

  always_comb begin
    op_data = '0;
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      if (32'(op_idx) == k) op_data = ops_q[k];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      for (int unsigned k = 0; k < NUM_OPS; k++) ops_q[k] <= '0;
    end else begin
      ops_q <= ops_d;
      if (s_axi.awvalid && s_axi.awready) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axi.awaddr;
      end
      if (s_axi.wvalid && s_axi.wready) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi.wdata;
        wstrb_q  <= s_axi.wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_resp;
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
      if (s_axi.arvalid && !rvalid_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  add_some_bitz_sum_engine #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_OPS    (NUM_OPS)
  ) u_sum_engine (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .start_i   (start),
    .op_idx_o  (op_idx),
    .op_data_i (op_data),
    .result_o  (result),
    .carry_o   (carry),
    .busy_o    (busy),
    .done_o    (done)
  );

endmodule

// File: tb/tb_add_some_bitz_regs.sv
// Scoreboard bench for add_some_bitz_regs: stimulus queues expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_add_some_bitz_regs;

  localparam logic [5:0] A_OP0 = 6'h00, A_OP1 = 6'h04, A_OP2 = 6'h08, A_OP3 = 6'h0C;
  localparam logic [5:0] A_CTRL = 6'h10, A_STATUS = 6'h14, A_RESULT = 6'h18;
  localparam logic [5:0] A_CARRY = 6'h1C;
  localparam logic [1:0] R_OK = 2'b00, R_ERR = 2'b10;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic ACLK;
  logic ARESET;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   busy_cycles = 0;
  exp_t exp_b[$];
  exp_t exp_r[$];

  add_some_bitz_regs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) axi ();

  add_some_bitz_regs #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6),
    .NUM_OPS    (4)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .s_axi  (axi),
    .busy_o (busy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge ACLK) if (busy) busy_cycles++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each presented response with the oldest expectation.
  always @(negedge ACLK) begin
    exp_t e;
    if (axi.bvalid && axi.bready) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected", 64'(axi.bresp), 64'hDEAD);
      end else begin
        e = exp_b.pop_front();
        check({e.name, "_bresp"}, 64'(axi.bresp), 64'(e.resp));
      end
    end
    if (axi.rvalid && axi.rready) begin
      if (exp_r.size() == 0) begin
        check("r_unexpected", 64'(axi.rdata), 64'hDEAD);
      end else begin
        e = exp_r.pop_front();
        check({e.name, "_rresp"}, 64'(axi.rresp), 64'(e.resp));
        check({e.name, "_rdata"}, 64'(axi.rdata), 64'(e.data));
      end
    end
  end

  task automatic wait_b(input string name);
    for (int c = 0; c < 30 && exp_b.size() != 0; c++) begin
      @(negedge ACLK);
      #1;
    end
    if (exp_b.size() != 0) begin
      check({name, "_b_timeout"}, 64'(exp_b.size()), 64'h0);
      exp_b.delete();
    end
  endtask

  task automatic wait_r(input string name);
    for (int c = 0; c < 30 && exp_r.size() != 0; c++) begin
      @(negedge ACLK);
      #1;
    end
    if (exp_r.size() != 0) begin
      check({name, "_r_timeout"}, 64'(exp_r.size()), 64'h0);
      exp_r.delete();
    end
  endtask

  task automatic wr(input string name, input logic [5:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] resp);
    exp_t e;
    logic aw_done, w_done, aw_hs, w_hs;
    e.name = name; e.data = '0; e.resp = resp;
    exp_b.push_back(e);
    @(posedge ACLK); #2;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      @(negedge ACLK);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(posedge ACLK); #2;
      if (aw_hs) begin axi.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs) begin axi.wvalid = 1'b0; w_done = 1'b1; end
    end
    if (!(aw_done && w_done)) begin
      check({name, "_wr_hs_timeout"}, 64'({aw_done, w_done}), 64'h3);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    end
    wait_b(name);
  endtask

  task automatic rd(input string name, input logic [5:0] addr, input logic [31:0] data,
                    input logic [1:0] resp);
    exp_t e;
    logic done_hs, hs;
    e.name = name; e.data = data; e.resp = resp;
    exp_r.push_back(e);
    @(posedge ACLK); #2;
    axi.araddr = addr; axi.arvalid = 1'b1;
    done_hs = 1'b0;
    for (int c = 0; c < 20 && !done_hs; c++) begin
      @(negedge ACLK);
      hs = axi.arvalid && axi.arready;
      @(posedge ACLK); #2;
      if (hs) begin axi.arvalid = 1'b0; done_hs = 1'b1; end
    end
    if (!done_hs) begin
      check({name, "_ar_timeout"}, 64'(done_hs), 64'h1);
      axi.arvalid = 1'b0;
    end
    wait_r(name);
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    @(negedge ACLK);
    while (busy && c < 50) begin
      @(negedge ACLK);
      c++;
    end
    if (busy) check({name, "_idle_timeout"}, 64'(busy), 64'h0);
  endtask

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 64'(axi.awready), 64'h1);
    check("rst_wready", 64'(axi.wready), 64'h1);
    check("rst_arready", 64'(axi.arready), 64'h1);
    check("rst_bvalid", 64'(axi.bvalid), 64'h0);
    check("rst_rvalid", 64'(axi.rvalid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    @(posedge ACLK); #2;
    ARESET = 1'b0;
    rd("rst_status", A_STATUS, 32'h0, R_OK);
    rd("rst_result", A_RESULT, 32'h0, R_OK);

    // Basic operand write/readback.
    wr("w_op0", A_OP0, 32'd1, 4'hF, R_OK);
    wr("w_op1", A_OP1, 32'd2, 4'hF, R_OK);
    wr("w_op2", A_OP2, 32'd3, 4'hF, R_OK);
    wr("w_op3", A_OP3, 32'd4, 4'hF, R_OK);
    rd("r_op0", A_OP0, 32'd1, R_OK);
    rd("r_op1", A_OP1, 32'd2, R_OK);
    rd("r_op2", A_OP2, 32'd3, R_OK);
    rd("r_op3", A_OP3, 32'd4, R_OK);

    // Sum 1+2+3+4, with an operand write attempted while the engine runs.
    busy_cycles = 0;
    wr("start1", A_CTRL, 32'h1, 4'hF, R_OK);
    wr("w_op1_busy", A_OP1, 32'h99, 4'hF, R_ERR);
    wait_idle("sum1");
    check("sum1_busy_cycles", 64'(busy_cycles), 64'd5);
    rd("sum1_status", A_STATUS, 32'h2, R_OK);
    rd("sum1_result", A_RESULT, 32'd10, R_OK);
    rd("sum1_carry", A_CARRY, 32'd0, R_OK);
    rd("op1_unchanged", A_OP1, 32'd2, R_OK);

    // Carry-out case.
    wr("w2_op0", A_OP0, 32'hFFFF_FFFF, 4'hF, R_OK);
    wr("w2_op1", A_OP1, 32'h1, 4'hF, R_OK);
    wr("w2_op2", A_OP2, 32'h1, 4'hF, R_OK);
    wr("w2_op3", A_OP3, 32'h0, 4'hF, R_OK);
    wr("start2", A_CTRL, 32'h1, 4'hF, R_OK);
    wait_idle("sum2");
    rd("sum2_result", A_RESULT, 32'h1, R_OK);
    rd("sum2_carry", A_CARRY, 32'h1, R_OK);
    rd("sum2_status", A_STATUS, 32'h2, R_OK);

    // Byte strobes.
    wr("w_op0_clr", A_OP0, 32'h0, 4'hF, R_OK);
    wr("w_op0_strb", A_OP0, 32'hAABB_CCDD, 4'b0101, R_OK);
    rd("r_op0_strb", A_OP0, 32'h00BB_00DD, R_OK);

    // W three cycles ahead of AW; BREADY stalled for four cycles.
    begin
      exp_t e;
      e.name = "w_first"; e.data = '0; e.resp = R_OK;
      exp_b.push_back(e);
      @(posedge ACLK); #2;
      axi.bready = 1'b0;
      axi.wdata = 32'h55; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      @(negedge ACLK);
      check("wf_wready_idle", 64'(axi.wready), 64'h1);
      @(posedge ACLK); #2;
      axi.wvalid = 1'b0;
      @(negedge ACLK);
      check("wf_wready_held", 64'(axi.wready), 64'h0);
      check("wf_awready_open", 64'(axi.awready), 64'h1);
      check("wf_bvalid_early", 64'(axi.bvalid), 64'h0);
      @(posedge ACLK);
      @(posedge ACLK); #2;
      axi.awaddr = A_OP2; axi.awvalid = 1'b1;
      @(negedge ACLK);
      check("wf_awready", 64'(axi.awready), 64'h1);
      @(posedge ACLK); #2;
      axi.awvalid = 1'b0;
      @(negedge ACLK);
      check("wf_bvalid_after_aw", 64'(axi.bvalid), 64'h0);
      for (int c = 0; c < 4; c++) begin
        @(negedge ACLK);
        check("wf_bvalid_hold", 64'(axi.bvalid), 64'h1);
      end
      @(posedge ACLK); #2;
      axi.bready = 1'b1;
      wait_b("w_first");
      rd("r_op2_wfirst", A_OP2, 32'h55, R_OK);
    end

    // Error responses.
    wr("w_result_ro", A_RESULT, 32'h123, 4'hF, R_ERR);
    wr("w_oob", 6'h20, 32'h123, 4'hF, R_ERR);
    rd("r_result_kept", A_RESULT, 32'h1, R_OK);
    rd("r_oob", 6'h3C, 32'h0, R_ERR);
    rd("r_ctrl", A_CTRL, 32'h0, R_OK);

    // Reset in the middle of accumulation.
    wr("start3", A_CTRL, 32'h1, 4'hF, R_OK);
    @(negedge ACLK);
    check("mid_busy", 64'(busy), 64'h1);
    @(posedge ACLK); #2;
    ARESET = 1'b1;
    @(posedge ACLK); #2;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_rst_busy", 64'(busy), 64'h0);
    rd("post_rst_status", A_STATUS, 32'h0, R_OK);
    rd("post_rst_result", A_RESULT, 32'h0, R_OK);
    rd("post_rst_op2", A_OP2, 32'h0, R_OK);

    repeat (3) @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
